// File: rtl/inv_diffusion.sv
// inv_diffusion
//   Inverse AES diffusion layer for the decrypt datapath: InvShiftRows, then
//   InvMixColumns, applied to a 4x4 byte state. InvMixColumns runs one column
//   per cycle through a single shared GF(2^8) column unit.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous, active-low reset
//   in_valid   state_in holds a state to process
//   in_ready   block can accept a state (high only while idle)
//   state_in   byte(r,c) = state_in[8*(4r+c) +: 8]
//   out_valid  state_out holds a completed result
//   out_ready  consumer accepts state_out
//   state_out  same byte layout as state_in
module inv_diffusion (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] MIX   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state_reg;
  logic [127:0] work_reg;
  logic [1:0]   col_reg;
  logic         out_valid_reg;
  logic [127:0] state_out_reg;

  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [7:0]   col_a [4];
  logic [7:0]   col_b [4];

  // Multiplication by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // The four InvMixColumns coefficients built from x, x^2 and x^3 multiples.
  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // InvShiftRows: row r rotated right by r positions.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      for (gj = 0; gj < 4; gj++) begin : g_col
        assign shifted[8*(4*gi+gj) +: 8] =
          work_reg[8*(4*gi + ((gj - gi + 4) % 4)) +: 8];
      end
    end
  endgenerate

  // Shared column unit operating on the column selected by col_reg.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      col_a[r] = work_reg[8*(4*r + int'(col_reg)) +: 8];
    end
  end

  // Each output row uses the same circulant coefficient pattern 0e,0b,0d,09
  // starting at its own row index.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign col_b[gi] = mule(col_a[gi])
                       ^ mulb(col_a[(gi + 1) % 4])
                       ^ muld(col_a[(gi + 2) % 4])
                       ^ mul9(col_a[(gi + 3) % 4]);
    end
  endgenerate

  // Work register with the current column replaced by its mixed value.
  always_comb begin
    mixed = work_reg;
    for (int r = 0; r < 4; r++) begin
      mixed[8*(4*r + int'(col_reg)) +: 8] = col_b[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      col_reg       <= '0;
      out_valid_reg <= 1'b0;
      state_out_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg  <= state_in;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          work_reg  <= shifted;
          col_reg   <= '0;
          state_reg <= MIX;
        end
        MIX: begin
          work_reg <= mixed;
          col_reg  <= col_reg + 2'd1;
          // Last column: publish the finished state directly from the mix path.
          if (col_reg == 2'd3) begin
            state_out_reg <= mixed;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign state_out = state_out_reg;

endmodule
